// File: rtl/wb_pkg.sv
// wb_pkg
// Shared definitions for the Wishbone register-bank slave: FSM state type,
// register index constants, the ID word, byte-select width and a helper that
// merges a byte-masked write into an existing register value.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_slv_state_t;

  localparam logic [1:0]  REG_SCRATCH0 = 2'd0;
  localparam logic [1:0]  REG_SCRATCH1 = 2'd1;
  localparam logic [1:0]  REG_ID       = 2'd2;
  localparam logic [1:0]  REG_COUNT    = 2'd3;

  localparam logic [31:0] ID_VALUE     = 32'h5742_0001;
  localparam int          SEL_W        = 4;

  // Replace only the bytes of oldVal whose select bit is set.
  function automatic logic [31:0] mergeBytes(input logic [31:0]      oldVal,
                                             input logic [31:0]      newVal,
                                             input logic [SEL_W-1:0] sel);
    logic [31:0] merged;
    merged = oldVal;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel[b]) merged[8*b +: 8] = newVal[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_slave_regs.sv
// wb_slave_regs
// Wishbone B4 classic slave with a four-word register bank (two byte-maskable
// scratch registers, a constant ID word and a count of ACK-terminated
// transfers) and a programmable number of wait states before termination.
// Unmapped word addresses are terminated with err_o and have no side effect.
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   cyc_i   bus cycle valid
//   stb_i   transfer request strobe
//   we_i    1 = write, 0 = read
//   adr_i   word address (ADDR_W bits, ADDR_W >= 2)
//   dat_i   write data
//   sel_i   byte enables, sel_i[n] covers dat_i[8n+7:8n]
//   dat_o   read data, non-zero only during the ack_o cycle of a read
//   ack_o   normal termination, one cycle
//   err_o   error termination for unmapped addresses, one cycle
module wb_slave_regs
  import wb_pkg::*;
#(
  parameter int          WAIT_STATES   = 0,
  parameter int          ADDR_W        = 4,
  parameter logic [31:0] RESET_SCRATCH = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [31:0]       dat_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              err_o
);

  // The counter holds the number of WAIT edges still to pass; it is only
  // loaded when WAIT_STATES is non-zero, so the zero case never uses it.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_slv_state_t     r_state;
  logic [3:0]        r_waitCnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0]       r_dat;
  logic [SEL_W-1:0]  r_sel;
  logic [31:0]       r_scratch0;
  logic [31:0]       r_scratch1;
  logic [31:0]       r_count;
  logic [31:0]       r_datOut;
  logic              r_ack;
  logic              r_err;

  logic              w_mapped;
  logic [1:0]        w_idx;
  logic              w_req;
  logic [31:0]       w_rdData;

  assign w_req    = cyc_i & stb_i;
  assign w_mapped = (32'(r_adr) < 32'd4);
  assign w_idx    = r_adr[1:0];

  // Read mux over the latched address; COUNT shows its pre-increment value
  // because the increment lands on the same edge that loads dat_o.
  always_comb begin
    w_rdData = 32'h0;
    case (w_idx)
      REG_SCRATCH0: w_rdData = r_scratch0;
      REG_SCRATCH1: w_rdData = r_scratch1;
      REG_ID:       w_rdData = ID_VALUE;
      REG_COUNT:    w_rdData = r_count;
      default:      w_rdData = 32'h0;
    endcase
  end

  // Request handshake, wait countdown and termination. The termination pulse
  // is raised on the edge leaving RESP, so it is visible while the FSM is
  // already back in IDLE; a master that drops stb_i on seeing ack_o is then
  // ready for its next request after two cycles at zero wait states.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_waitCnt <= 4'd0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= 32'h0;
      r_sel     <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_datOut  <= 32'h0;
    end else begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_datOut <= 32'h0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_we  <= we_i;
            r_adr <= adr_i;
            r_dat <= dat_i;
            r_sel <= sel_i;
            if (WAIT_STATES > 0) begin
              r_state   <= WAIT;
              r_waitCnt <= WAIT_LOAD;
            end else begin
              r_state <= RESP;
            end
          end
        end
        WAIT: begin
          if (!w_req) begin
            r_state <= IDLE;
          end else if (r_waitCnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          if (w_mapped) begin
            r_ack <= 1'b1;
            if (!r_we) r_datOut <= w_rdData;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Register bank: writes and the transfer count commit on the edge that
  // raises ack_o, using the request latched in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scratch0 <= RESET_SCRATCH;
      r_scratch1 <= RESET_SCRATCH;
      r_count    <= 32'h0;
    end else if (r_state == RESP && w_mapped) begin
      r_count <= r_count + 32'd1;
      if (r_we && w_idx == REG_SCRATCH0) r_scratch0 <= mergeBytes(r_scratch0, r_dat, r_sel);
      if (r_we && w_idx == REG_SCRATCH1) r_scratch1 <= mergeBytes(r_scratch1, r_dat, r_sel);
    end
  end

  assign dat_o = r_datOut;
  assign ack_o = r_ack;
  assign err_o = r_err;

endmodule

// File: tb/tb_wb_slave_regs.sv
// tb_wb_slave_regs
// Drives three slave instances (0, 3 and 5 wait states) with directed and
// random Wishbone transfers and compares every termination against a simple
// array-based model of the register map.
module tb_wb_slave_regs;

  logic        clk;
  logic        rstN;
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [3:0]  adr  [3];
  logic [31:0] datI [3];
  logic [3:0]  sel  [3];
  logic [31:0] datO [3];
  logic        ack  [3];
  logic        err  [3];

  logic [31:0] mScratch0 [3];
  logic [31:0] mScratch1 [3];
  logic [31:0] mCount    [3];

  int testsRun    = 0;
  int testsFailed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_slave_regs #(.WAIT_STATES(0), .ADDR_W(4), .RESET_SCRATCH(32'h0000_0000)) dut0 (
    .clk_i(clk), .rst_ni(rstN), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .dat_i(datI[0]), .sel_i(sel[0]), .dat_o(datO[0]),
    .ack_o(ack[0]), .err_o(err[0]));

  wb_slave_regs #(.WAIT_STATES(3), .ADDR_W(4), .RESET_SCRATCH(32'hA5A5_0F0F)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .dat_i(datI[1]), .sel_i(sel[1]), .dat_o(datO[1]),
    .ack_o(ack[1]), .err_o(err[1]));

  wb_slave_regs #(.WAIT_STATES(5), .ADDR_W(4), .RESET_SCRATCH(32'h1234_5678)) dut2 (
    .clk_i(clk), .rst_ni(rstN), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
    .adr_i(adr[2]), .dat_i(datI[2]), .sel_i(sel[2]), .dat_o(datO[2]),
    .ack_o(ack[2]), .err_o(err[2]));

  function automatic int waitStatesOf(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 5;
  endfunction

  function automatic logic [31:0] resetScratchOf(input int d);
    return (d == 0) ? 32'h0000_0000 : (d == 1) ? 32'hA5A5_0F0F : 32'h1234_5678;
  endfunction

  function automatic void resetModel();
    for (int d = 0; d < 3; d++) begin
      mScratch0[d] = resetScratchOf(d);
      mScratch1[d] = resetScratchOf(d);
      mCount[d]    = 32'h0;
    end
  endfunction

  function automatic logic [31:0] maskedWrite(input logic [31:0] cur, input logic [31:0] wd,
                                              input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (cur & ~m) | (wd & m);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One complete transfer on instance d, checked for latency, termination
  // kind, read data and the single-cycle pulse; then the model is updated.
  task automatic applyStimulus(input int d, input logic w, input logic [3:0] a,
                               input logic [31:0] wd, input logic [3:0] s);
    int          lat;
    logic        expAck;
    logic [31:0] expData;
    expAck  = (a < 4'd4);
    expData = 32'h0;
    if (!w && expAck) begin
      case (a)
        4'd0:    expData = mScratch0[d];
        4'd1:    expData = mScratch1[d];
        4'd2:    expData = 32'h5742_0001;
        default: expData = mCount[d];
      endcase
    end
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; datI[d] = wd; sel[d] = s;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack[d] && !err[d] && lat < 40);
    checkOutput($sformatf("inst%0d adr%0d latency", d, a), lat, waitStatesOf(d) + 1);
    checkOutput($sformatf("inst%0d adr%0d ack", d, a), {31'b0, ack[d]}, {31'b0, expAck});
    checkOutput($sformatf("inst%0d adr%0d err", d, a), {31'b0, err[d]}, {31'b0, !expAck});
    checkOutput($sformatf("inst%0d adr%0d dat_o", d, a), datO[d], expData);
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); #1;
    checkOutput($sformatf("inst%0d adr%0d pulse end", d, a), {30'b0, ack[d], err[d]}, 32'h0);
    checkOutput($sformatf("inst%0d adr%0d dat_o clear", d, a), datO[d], 32'h0);
    if (expAck) begin
      if (w && a == 4'd0) mScratch0[d] = maskedWrite(mScratch0[d], wd, s);
      if (w && a == 4'd1) mScratch1[d] = maskedWrite(mScratch1[d], wd, s);
      mCount[d] = mCount[d] + 32'd1;
    end
  endtask

  // Starts a write, withdraws the strobe after holdCycles WAIT edges and
  // checks that no termination ever appears.
  task automatic abortTransfer(input int d, input logic [3:0] a, input logic [31:0] wd,
                               input int holdCycles);
    logic sawTerm;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a; datI[d] = wd; sel[d] = 4'hF;
    @(posedge clk);
    repeat (holdCycles) @(posedge clk);
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    sawTerm = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) sawTerm = 1'b1;
    end
    checkOutput($sformatf("inst%0d abort no term", d), {31'b0, sawTerm}, 32'h0);
  endtask

  initial begin
    int          d;
    logic [3:0]  a;
    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = 4'h0; datI[i] = 32'h0; sel[i] = 4'h0;
    end
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("inst%0d reset ack", i), {31'b0, ack[i]}, 32'h0);
      checkOutput($sformatf("inst%0d reset err", i), {31'b0, err[i]}, 32'h0);
      checkOutput($sformatf("inst%0d reset dat_o", i), datO[i], 32'h0);
    end
    @(negedge clk);
    rstN = 1'b1;

    // Directed transfers from the register map description.
    applyStimulus(0, 1'b0, 4'd2, 32'h0, 4'hF);
    applyStimulus(0, 1'b1, 4'd0, 32'hDEAD_BEEF, 4'b0101);
    applyStimulus(0, 1'b0, 4'd0, 32'h0, 4'hF);
    checkOutput("scratch0 masked model", mScratch0[0], 32'h00AD_00EF);
    applyStimulus(0, 1'b1, 4'd7, 32'h0000_1234, 4'hF);
    applyStimulus(0, 1'b0, 4'd0, 32'h0, 4'hF);
    applyStimulus(0, 1'b0, 4'd3, 32'h0, 4'hF);
    applyStimulus(0, 1'b1, 4'd1, 32'hCAFE_F00D, 4'b0000);
    applyStimulus(0, 1'b0, 4'd1, 32'h0, 4'hF);
    applyStimulus(1, 1'b0, 4'd1, 32'h0, 4'hF);
    applyStimulus(1, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1, 1'b0, 4'd2, 32'h0, 4'hF);
    abortTransfer(2, 4'd0, 32'hBAD0_BAD0, 2);
    applyStimulus(2, 1'b0, 4'd0, 32'h0, 4'hF);
    applyStimulus(2, 1'b0, 4'd3, 32'h0, 4'hF);

    // Random transfers, biased towards mapped addresses.
    for (int n = 0; n < 60; n++) begin
      d = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      applyStimulus(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset asserted while ack_o is high must clear outputs without a clock edge.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 4'd3; sel[0] = 4'hF;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("pre-reset ack", {31'b0, ack[0]}, 32'h1);
    checkOutput("pre-reset count", datO[0], mCount[0]);
    #1 rstN = 1'b0;
    #1;
    checkOutput("async reset ack", {31'b0, ack[0]}, 32'h0);
    checkOutput("async reset dat_o", datO[0], 32'h0);
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    rstN = 1'b1;
    resetModel();

    // Five acknowledged transfers, then COUNT.
    for (int n = 0; n < 5; n++) applyStimulus(1, 1'b1, 4'(n % 4), 32'h1111_1111 * n, 4'hF);
    checkOutput("count five model", mCount[1], 32'd5);
    applyStimulus(1, 1'b0, 4'd3, 32'h0, 4'hF);

    // Reset during WAIT discards the pending write and clears COUNT.
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 4'd0; datI[2] = 32'hDEAD_BEEF; sel[2] = 4'hF;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("wait reset ack", {31'b0, ack[2]}, 32'h0);
    checkOutput("wait reset err", {31'b0, err[2]}, 32'h0);
    @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    rstN = 1'b1;
    resetModel();
    applyStimulus(2, 1'b0, 4'd3, 32'h0, 4'hF);
    applyStimulus(2, 1'b0, 4'd0, 32'h0, 4'hF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
